// File: rtl/axi_dw_w_upsizer_pkg.sv
// rtl/axi_dw_w_upsizer_pkg.sv - shared types, burst encodings and address stepping for the upsizer
package axi_dw_w_upsizer_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } dw_cmd_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } dw_state_e;

    // Address of the beat following 'addr' inside a burst; 12-bit arithmetic keeps
    // INCR bursts inside the 4 KiB page and WRAP bursts inside their wrap window.
    function automatic logic [11:0] dw_next_addr(
        input logic [11:0] addr,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [11:0] step;
        logic [11:0] incr;
        logic [11:0] wmask;
        step  = 12'd1 << size;
        incr  = (addr & ~(step - 12'd1)) + step;
        wmask = (({4'd0, len} + 12'd1) << size) - 12'd1;
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~wmask) | (incr & wmask);
            default:     return incr;
        endcase
    endfunction

endpackage

// File: rtl/axi_dw_w_upsizer_cmd_fifo.sv
// rtl/axi_dw_w_upsizer_cmd_fifo.sv - fall-through command queue holding AW-derived commands
module axi_dw_w_upsizer_cmd_fifo
    import axi_dw_w_upsizer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push_i,
    input  dw_cmd_t data_i,
    input  logic    pop_i,
    output dw_cmd_t data_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    dw_cmd_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // A write while full is only taken when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state, cleared by reset so a reset discards every queued command.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axi_dw_w_upsizer.sv
// rtl/axi_dw_w_upsizer.sv - packs narrow W beats into wide W beats following queued AW commands
module axi_dw_w_upsizer
    import axi_dw_w_upsizer_pkg::*;
#(
    parameter int unsigned SI_DATA_WIDTH  = 64,
    parameter int unsigned MI_DATA_WIDTH  = 256,
    parameter int unsigned USER_WIDTH     = 1,
    parameter int unsigned NR_OUTSTANDING = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [11:0]                cmd_addr_i,
    input  logic [7:0]                 cmd_len_i,
    input  logic [2:0]                 cmd_size_i,
    input  logic [1:0]                 cmd_burst_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [SI_DATA_WIDTH-1:0]   slv_w_data,
    input  logic [SI_DATA_WIDTH/8-1:0] slv_w_strb,
    input  logic                       slv_w_last,
    input  logic [USER_WIDTH-1:0]      slv_w_user,
    input  logic                       slv_w_valid,
    output logic                       slv_w_ready,
    output logic [MI_DATA_WIDTH-1:0]   mst_w_data,
    output logic [MI_DATA_WIDTH/8-1:0] mst_w_strb,
    output logic                       mst_w_last,
    output logic [USER_WIDTH-1:0]      mst_w_user,
    output logic                       mst_w_valid,
    input  logic                       mst_w_ready,
    output logic                       err_last_o
);

    localparam int unsigned SI_B    = SI_DATA_WIDTH / 8;
    localparam int unsigned MI_B    = MI_DATA_WIDTH / 8;
    localparam int unsigned SI_OFF  = $clog2(SI_B);
    localparam int unsigned MI_OFF  = $clog2(MI_B);
    localparam int unsigned NSLOT   = MI_B / SI_B;
    localparam int unsigned SLOT_W  = MI_OFF - SI_OFF;
    localparam logic [2:0]  SI_SIZE = 3'(SI_OFF);

    if (MI_DATA_WIDTH <= SI_DATA_WIDTH) begin : g_width_check
        $fatal(1, "axi_dw_w_upsizer: MI_DATA_WIDTH must be wider than SI_DATA_WIDTH");
    end

    dw_cmd_t                    cmd_in;
    dw_cmd_t                    cmd_head;
    logic                       q_full;
    logic                       q_empty;
    logic                       q_pop;

    dw_state_e                  state_q, state_d;
    logic [11:0]                addr_q, addr_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [7:0]                 len_q, len_d;
    logic [2:0]                 size_q, size_d;
    logic [1:0]                 burst_q, burst_d;
    logic [MI_DATA_WIDTH-1:0]   acc_data_q, acc_data_d;
    logic [MI_B-1:0]            acc_strb_q, acc_strb_d;
    logic [MI_DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [MI_B-1:0]            out_strb_q, out_strb_d;
    logic                       out_last_q, out_last_d;
    logic [USER_WIDTH-1:0]      out_user_q, out_user_d;
    logic                       out_valid_q, out_valid_d;
    logic                       err_q, err_d;

    logic [SLOT_W-1:0]          slot;
    logic [11:0]                next_addr;
    logic [MI_DATA_WIDTH-1:0]   merged_data;
    logic [MI_B-1:0]            merged_strb;
    logic                       is_last;
    logic                       close_beat;
    logic                       beat_fire;

    assign cmd_in      = '{addr: cmd_addr_i, len: cmd_len_i, size: cmd_size_i, burst: cmd_burst_i};
    assign cmd_ready_o = !q_full;

    axi_dw_w_upsizer_cmd_fifo #(
        .DEPTH (NR_OUTSTANDING)
    ) i_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_valid_i && cmd_ready_o),
        .data_i  (cmd_in),
        .pop_i   (q_pop),
        .data_o  (cmd_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign mst_w_data  = out_data_q;
    assign mst_w_strb  = out_strb_q;
    assign mst_w_last  = out_last_q;
    assign mst_w_user  = out_user_q;
    assign mst_w_valid = out_valid_q;
    assign err_last_o  = err_q;

    assign slot       = addr_q[MI_OFF-1:SI_OFF];
    assign next_addr  = dw_next_addr(addr_q, size_q, len_q, burst_q);
    assign is_last    = (cnt_q == 8'd0);
    assign close_beat = is_last || (burst_q == BURST_FIXED) ||
                        (next_addr[11:MI_OFF] != addr_q[11:MI_OFF]);
    assign beat_fire  = slv_w_valid && slv_w_ready;

    // Drop the incoming narrow beat's strobed bytes into its lane of the wide accumulator.
    always_comb begin
        merged_data = acc_data_q;
        merged_strb = acc_strb_q;
        for (int s = 0; s < NSLOT; s++) begin
            if (slot == SLOT_W'(s)) begin
                for (int b = 0; b < SI_B; b++) begin
                    if (slv_w_strb[b]) begin
                        merged_data[s*SI_DATA_WIDTH + b*8 +: 8] = slv_w_data[b*8 +: 8];
                        merged_strb[s*SI_B + b]                 = 1'b1;
                    end
                end
            end
        end
    end

    // Burst sequencing: load a command, walk its beats, present wide beats as they close.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        acc_data_d  = acc_data_q;
        acc_strb_d  = acc_strb_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        q_pop       = 1'b0;
        slv_w_ready = 1'b0;

        if (out_valid_q && mst_w_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    addr_d  = cmd_head.addr;
                    cnt_d   = cmd_head.len;
                    len_d   = cmd_head.len;
                    size_d  = cmd_head.size;
                    burst_d = cmd_head.burst;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                slv_w_ready = !out_valid_q || mst_w_ready;
                if (beat_fire) begin
                    addr_d = next_addr;
                    if (!is_last) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                    if (close_beat) begin
                        out_valid_d = 1'b1;
                        out_data_d  = merged_data;
                        out_strb_d  = merged_strb;
                        out_last_d  = is_last;
                        out_user_d  = slv_w_user;
                        acc_data_d  = '0;
                        acc_strb_d  = '0;
                    end else begin
                        acc_data_d  = merged_data;
                        acc_strb_d  = merged_strb;
                    end
                    // The internal beat count is authoritative; a disagreeing last only flags.
                    if (slv_w_last != is_last) begin
                        err_d = 1'b1;
                    end
                    if (is_last) begin
                        q_pop   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset drops any partially packed wide beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            acc_data_q  <= '0;
            acc_strb_q  <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            acc_data_q  <= acc_data_d;
            acc_strb_q  <= acc_strb_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    // Beats wider than the narrow port cannot be packed.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (cmd_valid_i && cmd_ready_o) |-> (cmd_size_i <= SI_SIZE));

endmodule
